// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory command port between an instruction-fetch
// requester (i_*) and a data-stage requester (d_*). One read may be outstanding
// at a time; stores are fire-and-forget and never leave IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_cmd_start/ready     fetch request handshake, i_addr fetch address
//   i_rdata/_valid        fetch response (pass-through of memory response)
//   d_cmd_start/ready     data request handshake, d_cmd_write selects store
//   d_addr/wdata/wmask    data command payload
//   d_rdata/_valid        load response (pass-through of memory response)
//   mem_cmd_*             command towards memory, mem_cmd_ready from memory
//   mem_rdata/_valid      memory read response
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; the
// default build uses fixed priority with the data requester over fetch.
module memory_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_start,
  output logic        i_cmd_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] ALL_ONES = '1;

  typedef enum logic { IDLE = 1'b0, READ_WAIT = 1'b1 } state_t;
  typedef enum logic { REQ_D = 1'b0, REQ_I = 1'b1 } req_t;

  state_t state, state_nxt;
  req_t   gnt, gnt_nxt;
  req_t   owner, owner_nxt;

  logic in_idle;
  logic granted_start;
  logic other_start;
  logic accept;
  logic accept_read;
  req_t gnt_other;

  assign in_idle       = (state == IDLE);
  assign granted_start = (gnt == REQ_D) ? d_cmd_start : i_cmd_start;
  assign other_start   = (gnt == REQ_D) ? i_cmd_start : d_cmd_start;
  assign gnt_other     = (gnt == REQ_D) ? REQ_I : REQ_D;

  // Readies are a function of state/gnt/mem ready only, never of any start.
  assign i_cmd_ready = rst_n & in_idle & (gnt == REQ_I) & mem_cmd_ready;
  assign d_cmd_ready = rst_n & in_idle & (gnt == REQ_D) & mem_cmd_ready;

  // Command mux; fetches are always full-word reads.
  assign mem_cmd_start = rst_n & in_idle & granted_start;
  assign mem_cmd_write = (gnt == REQ_D) ? d_cmd_write : 1'b0;
  assign mem_addr      = (gnt == REQ_D) ? d_addr      : i_addr;
  assign mem_wdata     = (gnt == REQ_D) ? d_wdata     : ALL_ONES;
  assign mem_wmask     = (gnt == REQ_D) ? d_wmask     : ALL_ONES;

  assign accept      = mem_cmd_start & mem_cmd_ready;
  assign accept_read = accept & ~mem_cmd_write;

  // Response routing: only the owner of the outstanding read sees data.
  assign i_rdata       = (!in_idle && owner == REQ_I) ? mem_rdata : ALL_ONES;
  assign d_rdata       = (!in_idle && owner == REQ_D) ? mem_rdata : ALL_ONES;
  assign i_rdata_valid = rst_n & !in_idle & (owner == REQ_I) & mem_rdata_valid;
  assign d_rdata_valid = rst_n & !in_idle & (owner == REQ_D) & mem_rdata_valid;

  // State, grant and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= REQ_D;
      owner <= REQ_D;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
    end
  end

  // Next-state, grant update and read ownership.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (accept_read) begin
          state_nxt = READ_WAIT;
          owner_nxt = gnt;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (accept) begin
          gnt_nxt = gnt_other;
        end else if (!granted_start && other_start) begin
          gnt_nxt = gnt_other;
        end
`else
        // Data requester wins any idle cycle it asks in; grant is sticky on accept.
        if (!accept) begin
          if (d_cmd_start) begin
            gnt_nxt = REQ_D;
          end else if (!granted_start && other_start) begin
            gnt_nxt = gnt_other;
          end
        end
`endif
      end
      READ_WAIT: begin
        if (mem_rdata_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter. Inputs change on the
// falling edge; combinational outputs are sampled 1ns later.
module tb_memory_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_cmd_start;
  logic        i_cmd_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_rdata_valid;
  logic        d_cmd_start;
  logic        d_cmd_write;
  logic        d_cmd_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_wmask;
  logic [31:0] d_rdata;
  logic        d_rdata_valid;
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;

  int vec;
  int miss;

  memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_start(i_cmd_start), .i_cmd_ready(i_cmd_ready), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write), .d_cmd_ready(d_cmd_ready),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet_inputs();
    i_cmd_start     = 1'b0;
    i_addr          = 32'h0;
    d_cmd_start     = 1'b0;
    d_cmd_write     = 1'b0;
    d_addr          = 32'h0;
    d_wdata         = 32'h0;
    d_wmask         = 32'h0;
    mem_cmd_ready   = 1'b1;
    mem_rdata       = 32'h0;
    mem_rdata_valid = 1'b0;
  endtask

  // Brings the DUT back to IDLE with gnt = D.
  task automatic do_reset();
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_cmd_start = 1'b1; d_cmd_start = 1'b1; d_cmd_write = 1'b0; d_addr = 32'h10;
    mem_cmd_ready = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'h55;
    #1;
    vec++; if (mem_cmd_start !== 1'b0) begin miss++; $display("FAIL rst_mem_start: got %0b want 0", mem_cmd_start); end
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL rst_i_ready: got %0b want 0", i_cmd_ready); end
    vec++; if (d_cmd_ready !== 1'b0) begin miss++; $display("FAIL rst_d_ready: got %0b want 0", d_cmd_ready); end
    vec++; if (i_rdata_valid !== 1'b0) begin miss++; $display("FAIL rst_i_valid: got %0b want 0", i_rdata_valid); end
    vec++; if (d_rdata_valid !== 1'b0) begin miss++; $display("FAIL rst_d_valid: got %0b want 0", d_rdata_valid); end
    vec++; if (i_rdata !== 32'hffffffff) begin miss++; $display("FAIL rst_i_rdata: got %h want ffffffff", i_rdata); end
    vec++; if (d_rdata !== 32'hffffffff) begin miss++; $display("FAIL rst_d_rdata: got %h want ffffffff", d_rdata); end
    // Release with a load pending: accepted at the first edge.
    @(negedge clk);
    i_cmd_start = 1'b0; mem_rdata_valid = 1'b0; rst_n = 1'b1;
    #1;
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL rst_release_d_ready: got %0b want 1", d_cmd_ready); end
    vec++; if (mem_cmd_start !== 1'b1) begin miss++; $display("FAIL rst_release_start: got %0b want 1", mem_cmd_start); end
    vec++; if (mem_addr !== 32'h10) begin miss++; $display("FAIL rst_release_addr: got %h want 00000010", mem_addr); end
    @(negedge clk);
    #1;
    vec++; if (mem_cmd_start !== 1'b0) begin miss++; $display("FAIL rst_first_rw_start: got %0b want 0", mem_cmd_start); end
    vec++; if (d_cmd_ready !== 1'b0) begin miss++; $display("FAIL rst_first_rw_ready: got %0b want 0", d_cmd_ready); end
    d_cmd_start = 1'b0; mem_rdata = 32'h11; mem_rdata_valid = 1'b1;
    #1;
    vec++; if (d_rdata !== 32'h11) begin miss++; $display("FAIL rst_first_rdata: got %h want 00000011", d_rdata); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(negedge clk);
    d_cmd_start = 1'b1; d_cmd_write = 1'b0; d_addr = 32'h100;
    i_cmd_start = 1'b1; i_addr = 32'h200;
    #1;
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL sim_d_ready: got %0b want 1", d_cmd_ready); end
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL sim_i_ready: got %0b want 0", i_cmd_ready); end
    vec++; if (mem_addr !== 32'h100) begin miss++; $display("FAIL sim_mem_addr: got %h want 00000100", mem_addr); end
    vec++; if (mem_cmd_write !== 1'b0) begin miss++; $display("FAIL sim_mem_write: got %0b want 0", mem_cmd_write); end
    @(negedge clk);
    d_cmd_start = 1'b0; mem_rdata = 32'hdeadbeef; mem_rdata_valid = 1'b1;
    #1;
    vec++; if (mem_cmd_start !== 1'b0) begin miss++; $display("FAIL sim_rw_start: got %0b want 0", mem_cmd_start); end
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL sim_rw_i_ready: got %0b want 0", i_cmd_ready); end
    vec++; if (d_rdata_valid !== 1'b1) begin miss++; $display("FAIL sim_d_valid: got %0b want 1", d_rdata_valid); end
    vec++; if (d_rdata !== 32'hdeadbeef) begin miss++; $display("FAIL sim_d_rdata: got %h want deadbeef", d_rdata); end
    vec++; if (i_rdata_valid !== 1'b0) begin miss++; $display("FAIL sim_i_valid: got %0b want 0", i_rdata_valid); end
    vec++; if (i_rdata !== 32'hffffffff) begin miss++; $display("FAIL sim_i_rdata: got %h want ffffffff", i_rdata); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    #1;
`ifndef ARB_ROUND_ROBIN_EN
    // Grant still on D: one switch cycle before the fetch can go.
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL sim_switch_i_ready: got %0b want 0", i_cmd_ready); end
    @(negedge clk);
    #1;
`endif
    vec++; if (i_cmd_ready !== 1'b1) begin miss++; $display("FAIL sim_fetch_ready: got %0b want 1", i_cmd_ready); end
    vec++; if (mem_addr !== 32'h200) begin miss++; $display("FAIL sim_fetch_addr: got %h want 00000200", mem_addr); end
    vec++; if (mem_wdata !== 32'hffffffff) begin miss++; $display("FAIL sim_fetch_wdata: got %h want ffffffff", mem_wdata); end
    vec++; if (mem_wmask !== 32'hffffffff) begin miss++; $display("FAIL sim_fetch_wmask: got %h want ffffffff", mem_wmask); end
    @(negedge clk);
    i_cmd_start = 1'b0; mem_rdata = 32'h12345678; mem_rdata_valid = 1'b1;
    #1;
    vec++; if (i_rdata_valid !== 1'b1) begin miss++; $display("FAIL sim_fetch_valid: got %0b want 1", i_rdata_valid); end
    vec++; if (i_rdata !== 32'h12345678) begin miss++; $display("FAIL sim_fetch_rdata: got %h want 12345678", i_rdata); end
    vec++; if (d_rdata_valid !== 1'b0) begin miss++; $display("FAIL sim_fetch_d_valid: got %0b want 0", d_rdata_valid); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_addr = 32'h300;
`ifndef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_cmd_start = 1'b1;
      d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'h1000 + 32'(4 * k);
      d_wdata = 32'(k); d_wmask = 32'hffffffff;
      #1;
      vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL b2b_d_ready[%0d]: got %0b want 1", k, d_cmd_ready); end
      vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL b2b_i_starve[%0d]: got %0b want 0", k, i_cmd_ready); end
      vec++; if (mem_cmd_write !== 1'b1) begin miss++; $display("FAIL b2b_write[%0d]: got %0b want 1", k, mem_cmd_write); end
      vec++; if (mem_addr !== 32'h1000 + 32'(4 * k)) begin miss++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, mem_addr, 32'h1000 + 32'(4 * k)); end
    end
    @(negedge clk);
    d_cmd_start = 1'b0;
    #1;
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL b2b_switch: got %0b want 0", i_cmd_ready); end
    @(negedge clk);
    #1;
    vec++; if (i_cmd_ready !== 1'b1) begin miss++; $display("FAIL b2b_i_ready: got %0b want 1", i_cmd_ready); end
    vec++; if (mem_addr !== 32'h300) begin miss++; $display("FAIL b2b_i_addr: got %h want 00000300", mem_addr); end
    @(negedge clk);
    i_cmd_start = 1'b0; mem_rdata = 32'h77; mem_rdata_valid = 1'b1;
    #1;
    vec++; if (i_rdata_valid !== 1'b1) begin miss++; $display("FAIL b2b_i_valid: got %0b want 1", i_rdata_valid); end
`else
    @(negedge clk);
    i_cmd_start = 1'b1;
    d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'h1000; d_wmask = 32'hffffffff;
    #1;
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL rr_d0_ready: got %0b want 1", d_cmd_ready); end
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL rr_d0_i_ready: got %0b want 0", i_cmd_ready); end
    vec++; if (mem_cmd_write !== 1'b1) begin miss++; $display("FAIL rr_d0_write: got %0b want 1", mem_cmd_write); end
    @(negedge clk);
    d_addr = 32'h1004;
    #1;
    vec++; if (i_cmd_ready !== 1'b1) begin miss++; $display("FAIL rr_i_ready: got %0b want 1", i_cmd_ready); end
    vec++; if (d_cmd_ready !== 1'b0) begin miss++; $display("FAIL rr_i_d_ready: got %0b want 0", d_cmd_ready); end
    vec++; if (mem_addr !== 32'h300) begin miss++; $display("FAIL rr_i_addr: got %h want 00000300", mem_addr); end
    vec++; if (mem_cmd_write !== 1'b0) begin miss++; $display("FAIL rr_i_write: got %0b want 0", mem_cmd_write); end
    @(negedge clk);
    i_cmd_start = 1'b0; mem_rdata = 32'h77; mem_rdata_valid = 1'b1;
    #1;
    vec++; if (i_rdata_valid !== 1'b1) begin miss++; $display("FAIL rr_i_valid: got %0b want 1", i_rdata_valid); end
    vec++; if (d_cmd_ready !== 1'b0) begin miss++; $display("FAIL rr_rw_d_ready: got %0b want 0", d_cmd_ready); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    #1;
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL rr_d1_ready: got %0b want 1", d_cmd_ready); end
    vec++; if (mem_addr !== 32'h1004) begin miss++; $display("FAIL rr_d1_addr: got %h want 00001004", mem_addr); end
    d_cmd_start = 1'b0;
`endif
    @(negedge clk);
    d_cmd_start = 1'b0; mem_rdata_valid = 1'b0;
  endtask

  task automatic test_fetch_latency();
    do_reset();
    @(negedge clk);
    i_cmd_start = 1'b1; i_addr = 32'h40;
    #1;
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL lat_switch_ready: got %0b want 0", i_cmd_ready); end
    vec++; if (mem_cmd_start !== 1'b0) begin miss++; $display("FAIL lat_switch_start: got %0b want 0", mem_cmd_start); end
    @(negedge clk);
    #1;
    vec++; if (i_cmd_ready !== 1'b1) begin miss++; $display("FAIL lat_i_ready: got %0b want 1", i_cmd_ready); end
    vec++; if (mem_cmd_start !== 1'b1) begin miss++; $display("FAIL lat_start: got %0b want 1", mem_cmd_start); end
    vec++; if (mem_addr !== 32'h40) begin miss++; $display("FAIL lat_addr: got %h want 00000040", mem_addr); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d_cmd_start = 1'b1; d_addr = 32'h80;
      #1;
      vec++; if (mem_cmd_start !== 1'b0) begin miss++; $display("FAIL lat_wait_start[%0d]: got %0b want 0", k, mem_cmd_start); end
      vec++; if (i_rdata_valid !== 1'b0) begin miss++; $display("FAIL lat_wait_i_valid[%0d]: got %0b want 0", k, i_rdata_valid); end
      vec++; if (d_cmd_ready !== 1'b0) begin miss++; $display("FAIL lat_wait_d_ready[%0d]: got %0b want 0", k, d_cmd_ready); end
    end
    @(negedge clk);
    i_cmd_start = 1'b0; d_cmd_start = 1'b0; mem_rdata = 32'hcafef00d; mem_rdata_valid = 1'b1;
    #1;
    vec++; if (i_rdata_valid !== 1'b1) begin miss++; $display("FAIL lat_i_valid: got %0b want 1", i_rdata_valid); end
    vec++; if (i_rdata !== 32'hcafef00d) begin miss++; $display("FAIL lat_i_rdata: got %h want cafef00d", i_rdata); end
    vec++; if (d_rdata_valid !== 1'b0) begin miss++; $display("FAIL lat_d_valid: got %0b want 0", d_rdata_valid); end
    vec++; if (d_rdata !== 32'hffffffff) begin miss++; $display("FAIL lat_d_rdata: got %h want ffffffff", d_rdata); end
    // Memory keeps valid high into IDLE: stray response is dropped.
    @(negedge clk);
    #1;
    vec++; if (i_rdata_valid !== 1'b0) begin miss++; $display("FAIL lat_stray_i_valid: got %0b want 0", i_rdata_valid); end
    vec++; if (d_rdata_valid !== 1'b0) begin miss++; $display("FAIL lat_stray_d_valid: got %0b want 0", d_rdata_valid); end
    vec++; if (i_rdata !== 32'hffffffff) begin miss++; $display("FAIL lat_stray_i_rdata: got %h want ffffffff", i_rdata); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_store_stall();
    do_reset();
    @(negedge clk);
    mem_cmd_ready = 1'b0;
    d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'ha0;
    d_wdata = 32'h1234; d_wmask = 32'hff00ff00;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      vec++; if (d_cmd_ready !== 1'b0) begin miss++; $display("FAIL stall_d_ready[%0d]: got %0b want 0", k, d_cmd_ready); end
      vec++; if (mem_cmd_start !== 1'b1) begin miss++; $display("FAIL stall_start[%0d]: got %0b want 1", k, mem_cmd_start); end
      vec++; if (mem_addr !== 32'ha0) begin miss++; $display("FAIL stall_addr[%0d]: got %h want 000000a0", k, mem_addr); end
      vec++; if (mem_wdata !== 32'h1234) begin miss++; $display("FAIL stall_wdata[%0d]: got %h want 00001234", k, mem_wdata); end
      vec++; if (mem_wmask !== 32'hff00ff00) begin miss++; $display("FAIL stall_wmask[%0d]: got %h want ff00ff00", k, mem_wmask); end
      vec++; if (mem_cmd_write !== 1'b1) begin miss++; $display("FAIL stall_write[%0d]: got %0b want 1", k, mem_cmd_write); end
    end
    @(negedge clk);
    mem_cmd_ready = 1'b1;
    #1;
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL stall_release_ready: got %0b want 1", d_cmd_ready); end
    vec++; if (mem_addr !== 32'ha0) begin miss++; $display("FAIL stall_release_addr: got %h want 000000a0", mem_addr); end
    // A store must not enter READ_WAIT: the next command is accepted at once.
    @(negedge clk);
    d_cmd_write = 1'b0; d_addr = 32'hb0;
    #1;
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL stall_no_rw: got %0b want 1", d_cmd_ready); end
    vec++; if (mem_cmd_write !== 1'b0) begin miss++; $display("FAIL stall_load_write: got %0b want 0", mem_cmd_write); end
    @(negedge clk);
    d_cmd_start = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h5a5a5a5a;
    #1;
    vec++; if (d_rdata_valid !== 1'b1) begin miss++; $display("FAIL stall_load_valid: got %0b want 1", d_rdata_valid); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
  endtask

  task automatic test_reset_in_read();
    do_reset();
    @(negedge clk);
    d_cmd_start = 1'b1; d_cmd_write = 1'b0; d_addr = 32'hc0;
    #1;
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL rir_accept: got %0b want 1", d_cmd_ready); end
    @(negedge clk);
    d_cmd_start = 1'b0;
    #1;
    vec++; if (d_cmd_ready !== 1'b0) begin miss++; $display("FAIL rir_in_rw: got %0b want 0", d_cmd_ready); end
    rst_n = 1'b0;
    #1;
    vec++; if (mem_cmd_start !== 1'b0) begin miss++; $display("FAIL rir_rst_start: got %0b want 0", mem_cmd_start); end
    vec++; if (d_rdata_valid !== 1'b0) begin miss++; $display("FAIL rir_rst_d_valid: got %0b want 0", d_rdata_valid); end
    @(negedge clk);
    rst_n = 1'b1; mem_rdata = 32'hbad0bad0; mem_rdata_valid = 1'b1;
    #1;
    vec++; if (d_rdata_valid !== 1'b0) begin miss++; $display("FAIL rir_late_d_valid: got %0b want 0", d_rdata_valid); end
    vec++; if (i_rdata_valid !== 1'b0) begin miss++; $display("FAIL rir_late_i_valid: got %0b want 0", i_rdata_valid); end
    vec++; if (d_rdata !== 32'hffffffff) begin miss++; $display("FAIL rir_late_d_rdata: got %h want ffffffff", d_rdata); end
    vec++; if (d_cmd_ready !== 1'b1) begin miss++; $display("FAIL rir_idle_gnt_d: got %0b want 1", d_cmd_ready); end
    vec++; if (i_cmd_ready !== 1'b0) begin miss++; $display("FAIL rir_idle_i_ready: got %0b want 0", i_cmd_ready); end
    @(negedge clk);
    mem_rdata_valid = 1'b0;
  endtask

  initial begin
    vec = 0;
    miss = 0;
    rst_n = 1'b0;
    quiet_inputs();
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_fetch_latency();
    test_store_stall();
    test_reset_in_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (posedge) and rst_n.
REQ-002 The ports SHALL be, as name  direction  width  meaning:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- i_cmd_start  in  1  fetch read request
- i_cmd_ready  out  1  fetch command accepted when high together with start
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch read data
- i_rdata_valid  out  1  fetch data valid
- d_cmd_start  in  1  data-stage request
- d_cmd_write  in  1  1 = store, 0 = load
- d_cmd_ready  out  1  data command accepted
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wmask  in  32  store mask
- d_rdata  out  32  load data
- d_rdata_valid  out  1  load data valid
- mem_cmd_start  out  1  to memory
- mem_cmd_write  out  1  to memory
- mem_cmd_ready  in  1  from memory
- mem_addr  out  32  to memory
- mem_wdata  out  32  to memory
- mem_wmask  out  32  to memory
- mem_rdata  in  32  from memory
- mem_rdata_valid  in  1  from memory

Function
REQ-003 A command SHALL be accepted in a cycle where X_cmd_start and X_cmd_ready are both 1.
REQ-004 States: IDLE and READ_WAIT; registers: gnt (I or D) and owner (I or D).
REQ-005 Ready outputs SHALL depend only on state, gnt, mem_cmd_ready and rst_n, never on any *_cmd_start, so that no combinational loop forms with requesters that drive start from ready.
REQ-006 In IDLE, ready SHALL be as follows: granted requester's ready = mem_cmd_ready; other requester's ready = 0.
REQ-007 In IDLE, the memory command mux SHALL select by gnt:
- gnt=D: mem_* = d_*.
- gnt=I: mem_cmd_start = i_cmd_start, mem_cmd_write = 0, mem_addr = i_addr, mem_wdata = 32'hffffffff, mem_wmask = 32'hffffffff.
REQ-008 On acceptance of a load or fetch in IDLE, the block SHALL go to READ_WAIT with owner = gnt.
REQ-009 On acceptance of a store, the block SHALL stay in IDLE; stores produce no response.
REQ-010 In READ_WAIT, mem_cmd_start SHALL be 0 and both readies SHALL be 0.
REQ-011 In READ_WAIT, the owner's rdata SHALL be mem_rdata and the owner's rdata_valid SHALL be mem_rdata_valid, with 0-cycle pass-through.
REQ-012 In READ_WAIT, on mem_rdata_valid the block SHALL go to IDLE the next cycle.
REQ-013 The non-owner's rdata_valid SHALL be 0 at all times, and both rdata_valid outputs SHALL be 0 in IDLE; a stray mem_rdata_valid in IDLE is dropped.
REQ-014 Unused rdata outputs SHALL read 32'hffffffff.
REQ-015 In an IDLE cycle without acceptance, gnt SHALL switch to the other requester if the granted requester's start=0 and the other's start=1; this costs a 1-cycle switch penalty.
REQ-016 On simultaneous start from both requesters in IDLE, the current gnt SHALL win; the loser waits and SHALL hold its request stable.
REQ-017 gnt SHALL change only in IDLE; it SHALL be held through READ_WAIT.

Reset
REQ-018 While rst_n=0, the block SHALL be in IDLE, gnt = D, owner = D.
REQ-019 While rst_n=0, mem_cmd_start, i_cmd_ready, d_cmd_ready, i_rdata_valid and d_rdata_valid SHALL be 0.
REQ-020 Reset asserted during READ_WAIT SHALL abandon the outstanding read; its late response is dropped per REQ-013.
REQ-021 After deassertion, the first acceptance SHALL be possible in the first clk edge.

Configuration
REQ-022 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-023 Without ARB_ROUND_ROBIN_EN (fixed priority, D over I):
- in an IDLE cycle without acceptance with d_cmd_start=1, gnt SHALL become D;
- after any acceptance, gnt SHALL be unchanged.
REQ-024 With ARB_ROUND_ROBIN_EN:
- after each accepted command, gnt SHALL flip to the other requester;
- REQ-015 SHALL still apply.

Verification
REQ-025 Simultaneous requests, gnt=D, mem_cmd_ready=1, d load addr 0x100, i fetch addr 0x200 -> D accepted first, i_cmd_ready=0; rdata 0xdeadbeef returns on d_rdata with d_rdata_valid=1; the fetch to 0x200 is accepted later.
REQ-026 Fixed priority, D issues back-to-back stores while I requests -> I starves until d_cmd_start=0; with ARB_ROUND_ROBIN_EN, accepted commands alternate D, I, D.
REQ-027 gnt=I, fetch 0x40 accepted, memory responds after 5 cycles -> mem_cmd_start=0 for 5 cycles, i_rdata_valid pulses once, d_rdata_valid stays 0.
REQ-028 Store with mem_cmd_ready=0 for 3 cycles then 1 -> d_cmd_ready=0 for 3 cycles; mem_addr/wdata/wmask equal the d_* values throughout; no READ_WAIT entered.
REQ-029 rst_n pulsed low in READ_WAIT, then mem_rdata_valid=1 arrives -> both rdata_valid outputs stay 0; state IDLE, gnt=D.
REQ-030 Only I requests while gnt=D -> one cycle with i_cmd_ready=0, then gnt=I and the fetch is accepted on the next ready.
